// File: rtl/mist_sys_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mist_sys_ctrl
// Description : Reset sequencer (edge-triggered, fixed-length sys_res pulse)
//               and CPU clock-enable generator with a runtime divisor.
//               Optional CPU watchdog enabled by defining MIST_SYS_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mist_sys_ctrl #(
  parameter int                 NUM_SRC  = 2,
  parameter logic [NUM_SRC-1:0] SRC_FALL = 2'b01,
  parameter int                 RES_LEN  = 16,
  parameter int                 DIV_W    = 16,
  parameter int                 WDOG_LEN = 4096
) (
  input  logic               clk,
  input  logic               res,
  input  logic [NUM_SRC-1:0] src,
  input  logic               hold,
  input  logic [DIV_W-1:0]   cpu_div,
  input  logic               heartbeat,
  output logic               sys_res,
  output logic               cpu_tick,
  output logic [NUM_SRC-1:0] res_cause,
  output logic               wdog_trip
);

  localparam int                  c_PCNT_W    = (RES_LEN > 1) ? $clog2(RES_LEN) : 1;
  localparam logic [c_PCNT_W-1:0] c_PCNT_LAST = c_PCNT_W'(RES_LEN - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_PULSE = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_PCNT_W-1:0] r_pcnt;
  logic [c_PCNT_W-1:0] w_pcnt_nxt;
  logic [NUM_SRC-1:0]  r_cause;
  logic [NUM_SRC-1:0]  w_cause_nxt;
  logic                r_trip;
  logic                w_trip_nxt;
  logic                r_sys_res;
  logic                w_sys_res_nxt;
  logic [NUM_SRC-1:0]  r_prev;
  logic [NUM_SRC-1:0]  w_fire;
  logic                w_src_any;
  logic                w_wd_fire;

  logic [DIV_W-1:0]    r_div_cnt;
  logic [DIV_W-1:0]    w_div_nxt;
  logic [DIV_W-1:0]    w_dm1;
  logic                w_held;
  logic                r_tick;

  // A source fires on a level change that lands on its active level.
  assign w_fire    = (r_prev ^ src) & (src ^ SRC_FALL);
  assign w_src_any = |w_fire;

  always_ff @(posedge clk) begin
    r_prev <= src;
  end

  // --------------------------------------------------------------------------
  // Pulse FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (res) begin
      r_state   <= S_PULSE;
      r_pcnt    <= '0;
      r_cause   <= '0;
      r_trip    <= 1'b0;
      r_sys_res <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_pcnt    <= w_pcnt_nxt;
      r_cause   <= w_cause_nxt;
      r_trip    <= w_trip_nxt;
      r_sys_res <= w_sys_res_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_cause_nxt = r_cause;
    w_trip_nxt  = r_trip;
    case (r_state)
      S_IDLE: begin
        if (w_src_any || w_wd_fire) begin
          w_state_nxt = S_PULSE;
          w_pcnt_nxt  = '0;
          if (w_src_any) begin
            w_cause_nxt = w_fire;
            w_trip_nxt  = w_wd_fire;
          end else begin
            w_trip_nxt  = 1'b1;
          end
        end
      end
      S_PULSE: begin
        // Late events restart the count so the core sees a full-length pulse.
        if (w_src_any) begin
          w_pcnt_nxt  = '0;
          w_cause_nxt = r_cause | w_fire;
        end else if (r_pcnt == c_PCNT_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_pcnt_nxt  = r_pcnt + c_PCNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_sys_res_nxt = (w_state_nxt == S_PULSE);

  // --------------------------------------------------------------------------
  // CPU tick divider
  // --------------------------------------------------------------------------
  // The counter wraps after a tick rather than at D-1, so a divisor shrunk
  // below the current count still yields one tick before the new period.
  assign w_dm1     = (cpu_div == '0) ? '0 : cpu_div - DIV_W'(1);
  assign w_held    = r_sys_res || w_sys_res_nxt || hold;
  assign w_div_nxt = r_tick ? '0 : r_div_cnt + DIV_W'(1);

  always_ff @(posedge clk) begin
    if (res || w_held) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_tick    <= (w_div_nxt >= w_dm1);
    end
  end

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
`ifdef MIST_SYS_WDOG_EN
  localparam int c_WD_W = $clog2(WDOG_LEN + 1);

  logic [c_WD_W-1:0] r_wd_cnt;

  always_ff @(posedge clk) begin
    if (res || heartbeat || w_held) begin
      r_wd_cnt <= '0;
    end else if (r_tick) begin
      r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
    end
  end

  assign w_wd_fire = (r_wd_cnt == c_WD_W'(WDOG_LEN));
`else
  localparam int c_unused_wdog_len = WDOG_LEN;
  logic w_unused_heartbeat;
  assign w_unused_heartbeat = heartbeat;
  assign w_wd_fire          = 1'b0;
`endif

  assign sys_res   = r_sys_res;
  assign cpu_tick  = r_tick;
  assign res_cause = r_cause;
`ifdef MIST_SYS_WDOG_EN
  assign wdog_trip = r_trip;
`else
  assign wdog_trip = 1'b0;
`endif

endmodule
`default_nettype wire
